// File: rtl/lm_encoder_if.sv
// Event/FIFO-write bundle between the LED-event producers, the encoder and the
// LED-manager FIFO write port.
interface lm_encoder_if #(
    parameter int WIDTH = 8
);
    logic             err_valid;
    logic [WIDTH-3:0] err_code;
    logic             data_valid;
    logic [WIDTH-3:0] data_val;
    logic             data_ready;
    logic             act_valid;
    logic [WIDTH-3:0] act_val;
    logic             act_ready;
    logic             fifo_full;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clr_overrun;
    logic             err_overrun;

    modport master (
        output err_valid, err_code,
        output data_valid, data_val,
        output act_valid, act_val,
        output fifo_full, clr_overrun,
        input  data_ready, act_ready,
        input  wr_en, wr_data, err_overrun
    );

    modport slave (
        input  err_valid, err_code,
        input  data_valid, data_val,
        input  act_valid, act_val,
        input  fifo_full, clr_overrun,
        output data_ready, act_ready,
        output wr_en, wr_data, err_overrun
    );
endinterface

// File: rtl/lm_encoder.sv
// LED-manager write-side encoder: tags error/data/actualization events as LED
// words and writes them into the LED FIFO, spaced so each pattern stays visible.
module lm_encoder #(
    parameter int WIDTH_LEDS = 8,
    parameter int WIDTH      = WIDTH_LEDS,
    parameter int GAP        = 4
) (
    input  logic         clk,
    input  logic         rst,
    lm_encoder_if.slave  bus
);
    localparam int PW = WIDTH - 2;
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(GAP - 1);

    localparam logic [1:0] TAG_ERR  = 2'b11;
    localparam logic [1:0] TAG_DATA = 2'b01;
    localparam logic [1:0] TAG_ACT  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ERR,
        SRC_DATA,
        SRC_ACT
    } src_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    src_t           win;
    logic           do_write;
    logic [WIDTH-1:0] word;

    logic             wr_en_reg;
    logic [WIDTH-1:0] wr_data_reg;
    logic             last_served_reg;   // 0: data served last, 1: actualization
    logic             err_overrun_reg;

    logic             err_pend_reg;
    logic [PW-1:0]    err_code_reg;
    logic             err_write;
    logic             overrun_set;

    // Handshake slots: index 0 is data, index 1 is actualization.
    logic [1:0]       hs_valid;
    logic [PW-1:0]    hs_val [2];
    logic [1:0]       hs_pend;
    logic [1:0]       hs_ready;
    logic [1:0]       hs_clear;
    logic [PW-1:0]    hs_payload [2];

    assign hs_valid  = {bus.act_valid, bus.data_valid};
    assign hs_val[0] = bus.data_val;
    assign hs_val[1] = bus.act_val;
    assign hs_clear  = {do_write && (win == SRC_ACT), do_write && (win == SRC_DATA)};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic          pend_reg;
            logic [PW-1:0] payload_reg;

            // Ready is gated by rst so producers see no slot while in reset.
            assign hs_ready[gi]   = !pend_reg && rst;
            assign hs_pend[gi]    = pend_reg;
            assign hs_payload[gi] = payload_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    pend_reg    <= 1'b0;
                    payload_reg <= '0;
                end else if (hs_valid[gi] && hs_ready[gi]) begin
                    pend_reg    <= 1'b1;
                    payload_reg <= hs_val[gi];
                end else if (hs_clear[gi]) begin
                    pend_reg    <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.data_ready = hs_ready[0];
    assign bus.act_ready  = hs_ready[1];

    assign err_write   = do_write && (win == SRC_ERR);
    assign overrun_set = bus.err_valid && err_pend_reg && !err_write;

    // A fresh error arriving on the write edge refills the slot, so it stays pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_pend_reg <= 1'b0;
            err_code_reg <= '0;
        end else if (bus.err_valid) begin
            err_pend_reg <= 1'b1;
            err_code_reg <= bus.err_code;
        end else if (err_write) begin
            err_pend_reg <= 1'b0;
        end
    end

    always_comb begin
        win = SRC_NONE;
        if (err_pend_reg) begin
            win = SRC_ERR;
        end else if (hs_pend[0] && hs_pend[1]) begin
            win = last_served_reg ? SRC_DATA : SRC_ACT;
        end else if (hs_pend[0]) begin
            win = SRC_DATA;
        end else if (hs_pend[1]) begin
            win = SRC_ACT;
        end
    end

    always_comb begin
        word = '0;
        case (win)
            SRC_ERR:  word = {TAG_ERR,  err_code_reg};
            SRC_DATA: word = {TAG_DATA, hs_payload[0]};
            SRC_ACT:  word = {TAG_ACT,  hs_payload[1]};
            default:  word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_write   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if ((win != SRC_NONE) && !bus.fifo_full) begin
                    do_write   = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_reg       <= 1'b0;
            wr_data_reg     <= '0;
            last_served_reg <= 1'b1;
            err_overrun_reg <= 1'b0;
        end else begin
            wr_en_reg <= do_write;
            if (do_write) begin
                wr_data_reg <= word;
            end
            if (do_write && (win == SRC_DATA)) begin
                last_served_reg <= 1'b0;
            end else if (do_write && (win == SRC_ACT)) begin
                last_served_reg <= 1'b1;
            end
            if (overrun_set) begin
                err_overrun_reg <= 1'b1;
            end else if (bus.clr_overrun) begin
                err_overrun_reg <= 1'b0;
            end
        end
    end

    assign bus.wr_en       = wr_en_reg;
    assign bus.wr_data     = wr_data_reg;
    assign bus.err_overrun = err_overrun_reg;
endmodule

// File: tb/tb_lm_encoder.sv
// Bench for lm_encoder: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against an event-level model.
module tb_lm_encoder;
    localparam int W   = 8;
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lm_encoder_if #(.WIDTH(W)) bus ();

    lm_encoder #(.WIDTH(W), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Write log observed on the DUT: edge number and word.
    int         log_c[$];
    logic [7:0] log_d[$];

    // Reference model state.
    bit         m_init = 0;
    bit         m_err_pend;
    logic [5:0] m_err_code;
    bit         m_pend[2];
    logic [5:0] m_pay[2];
    bit         m_last_act;
    int         m_next_ok;
    bit         m_wr_en;
    logic [7:0] m_wr_data;
    bit         m_ovr;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // The model tracks the earliest edge a write may occur rather than FSM state.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_init     = 1;
            m_err_pend = 0;
            m_err_code = '0;
            m_pend     = '{0, 0};
            m_pay      = '{6'd0, 6'd0};
            m_last_act = 1;
            m_next_ok  = cyc + 1;
            m_wr_en    = 0;
            m_wr_data  = '0;
            m_ovr      = 0;
        end else if (m_init) begin
            int  w;
            bit  rdy0, rdy1, ovr;
            rdy0 = !m_pend[0];
            rdy1 = !m_pend[1];
            w = -1;
            if (cyc >= m_next_ok && !bus.fifo_full) begin
                if (m_err_pend)                 w = 0;
                else if (m_pend[0] && m_pend[1]) w = m_last_act ? 1 : 2;
                else if (m_pend[0])             w = 1;
                else if (m_pend[1])             w = 2;
            end
            m_wr_en = (w >= 0);
            if (w == 0) m_wr_data = {2'b11, m_err_code};
            if (w == 1) begin m_wr_data = {2'b01, m_pay[0]}; m_pend[0] = 0; m_last_act = 0; end
            if (w == 2) begin m_wr_data = {2'b10, m_pay[1]}; m_pend[1] = 1'b0; m_last_act = 1; end
            if (w >= 0) m_next_ok = cyc + GAP + 1;
            ovr = bus.err_valid && m_err_pend && (w != 0);
            if (bus.err_valid) begin
                m_err_pend = 1;
                m_err_code = bus.err_code;
            end else if (w == 0) begin
                m_err_pend = 0;
            end
            if (ovr) m_ovr = 1;
            else if (bus.clr_overrun) m_ovr = 0;
            if (bus.data_valid && rdy0) begin m_pend[0] = 1; m_pay[0] = bus.data_val; end
            if (bus.act_valid && rdy1)  begin m_pend[1] = 1; m_pay[1] = bus.act_val; end
        end
        #1;
        if (m_init) begin
            chk("wr_en",       {31'd0, bus.wr_en},       {31'd0, m_wr_en});
            chk("wr_data",     {24'd0, bus.wr_data},     {24'd0, m_wr_data});
            chk("data_ready",  {31'd0, bus.data_ready},  {31'd0, (!m_pend[0] && rst)});
            chk("act_ready",   {31'd0, bus.act_ready},   {31'd0, (!m_pend[1] && rst)});
            chk("err_overrun", {31'd0, bus.err_overrun}, {31'd0, m_ovr});
        end
        if (bus.wr_en === 1'b1) begin
            log_c.push_back(cyc);
            log_d.push_back(bus.wr_data);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_log();
        log_c.delete();
        log_d.delete();
    endtask

    task automatic wait_writes(input string name, input int n, input int budget);
        int k = 0;
        while (log_d.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, log_d.size(), n);
    endtask

    int hs;

    initial begin
        bus.err_valid   = 0; bus.err_code = '0;
        bus.data_valid  = 0; bus.data_val = '0;
        bus.act_valid   = 0; bus.act_val  = '0;
        bus.fifo_full   = 0; bus.clr_overrun = 0;
        rst = 0;

        // Reset state
        idle(3);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 0);
        chk("rst_data_ready", {31'd0, bus.data_ready}, 0);
        chk("rst_overrun", {31'd0, bus.err_overrun}, 0);
        rst = 1;
        @(negedge clk);
        chk("rel_data_ready", {31'd0, bus.data_ready}, 1);
        chk("rel_act_ready", {31'd0, bus.act_ready}, 1);

        // Single data event
        clear_log();
        bus.data_valid = 1; bus.data_val = 6'h15; hs = cyc + 1;
        @(negedge clk);
        bus.data_valid = 0;
        chk("single_ready_drop", {31'd0, bus.data_ready}, 0);
        wait_writes("single_timeout", 1, 10);
        if (log_d.size() >= 1) begin
            chk("single_word", {24'd0, log_d[0]}, 32'h55);
            chk("single_latency", log_c[0], hs + 1);
        end
        chk("single_ready_back", {31'd0, bus.data_ready}, 1);
        idle(8);

        // Error priority over data
        clear_log();
        bus.err_valid = 1; bus.err_code = 6'h01;
        bus.data_valid = 1; bus.data_val = 6'h02; hs = cyc + 1;
        @(negedge clk);
        bus.err_valid = 0; bus.data_valid = 0;
        wait_writes("prio_timeout", 2, 30);
        if (log_d.size() >= 2) begin
            chk("prio_first", {24'd0, log_d[0]}, 32'hC1);
            chk("prio_first_lat", log_c[0], hs + 1);
            chk("prio_second", {24'd0, log_d[1]}, 32'h42);
            chk("prio_spacing", log_c[1] - log_c[0], GAP + 1);
        end
        idle(8);

        // Fair alternation starting from a fresh reset
        rst = 0; @(negedge clk); rst = 1;
        clear_log();
        bus.data_valid = 1; bus.data_val = 6'h03;
        bus.act_valid  = 1; bus.act_val  = 6'h04;
        wait_writes("alt_timeout", 6, 60);
        bus.data_valid = 0; bus.act_valid = 0;
        for (int i = 0; i < 6 && i < log_d.size(); i++) begin
            chk("alt_word", {24'd0, log_d[i]}, (i % 2 == 0) ? 32'h43 : 32'h84);
            if (i > 0) chk("alt_spacing", log_c[i] - log_c[i-1], GAP + 1);
        end
        idle(20);

        // FIFO full stall
        clear_log();
        bus.fifo_full = 1;
        bus.data_valid = 1; bus.data_val = 6'h15;
        @(negedge clk);
        bus.data_valid = 0;
        idle(20);
        chk("stall_no_write", log_d.size(), 0);
        bus.fifo_full = 0; hs = cyc + 1;
        wait_writes("stall_timeout", 1, 10);
        if (log_d.size() >= 1) begin
            chk("stall_release_lat", log_c[0], hs);
            chk("stall_word", {24'd0, log_d[0]}, 32'h55);
        end
        idle(8);

        // Error overrun
        clear_log();
        bus.fifo_full = 1;
        @(negedge clk);
        bus.err_valid = 1; bus.err_code = 6'h0A;
        @(negedge clk);
        bus.err_code = 6'h0B;
        @(negedge clk);
        bus.err_valid = 0;
        chk("ovr_set", {31'd0, bus.err_overrun}, 1);
        bus.fifo_full = 0;
        idle(12);
        chk("ovr_count", log_d.size(), 1);
        if (log_d.size() >= 1) chk("ovr_word", {24'd0, log_d[0]}, 32'hCB);
        chk("ovr_sticky", {31'd0, bus.err_overrun}, 1);
        bus.clr_overrun = 1;
        @(negedge clk);
        bus.clr_overrun = 0;
        chk("ovr_clear", {31'd0, bus.err_overrun}, 0);
        idle(4);

        // Reset during GAP with actualization pending
        clear_log();
        bus.err_valid = 1; bus.err_code = 6'h05;
        bus.act_valid = 1; bus.act_val  = 6'h07;
        @(negedge clk);
        bus.err_valid = 0; bus.act_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("mid_rst_wr_en", {31'd0, bus.wr_en}, 0);
        chk("mid_rst_ovr", {31'd0, bus.err_overrun}, 0);
        chk("mid_rst_act_ready", {31'd0, bus.act_ready}, 0);
        rst = 1;
        idle(15);
        chk("mid_rst_count", log_d.size(), 1);
        if (log_d.size() >= 1) chk("mid_rst_word", {24'd0, log_d[0]}, 32'hC5);
        clear_log();
        bus.data_valid = 1; bus.data_val = 6'h2A; hs = cyc + 1;
        @(negedge clk);
        bus.data_valid = 0;
        wait_writes("post_rst_timeout", 1, 10);
        if (log_d.size() >= 1) begin
            chk("post_rst_word", {24'd0, log_d[0]}, 32'h6A);
            chk("post_rst_lat", log_c[0], hs + 1);
        end
        idle(8);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bus.err_valid   = ($urandom_range(0, 7) == 0);
            bus.err_code    = 6'($urandom);
            bus.data_valid  = $urandom_range(0, 1) == 1;
            bus.data_val    = 6'($urandom);
            bus.act_valid   = $urandom_range(0, 1) == 1;
            bus.act_val     = 6'($urandom);
            bus.fifo_full   = ($urandom_range(0, 3) == 0);
            bus.clr_overrun = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        bus.err_valid = 0; bus.data_valid = 0; bus.act_valid = 0;
        bus.fifo_full = 0; bus.clr_overrun = 0; rst = 1;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
